bank_reader: RTL and testbench

- Read-side consumer of the NM line-buffer banks filled by the row writer.
- Tracks which banks hold complete rows and reads the KW oldest full rows in lock-step, column by column.
- Presents one KW-tall window column per handshake to the convolution datapath.
- Releases the oldest bank with a one-cycle mem_used pulse at each row end, so the writer can refill it.

---
 rtl/bank_reader.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_bank_reader.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_reader.sv
`default_nettype none
// ============================================================================
//  Module      : bank_reader
//  Description : Read-side consumer of the NM line-buffer banks filled by the
//                row writer. Tracks which banks hold complete rows, reads the
//                KW oldest full rows in lock-step column by column, presents
//                one KW-tall window column per handshake, and releases the
//                oldest bank with a one-cycle mem_used pulse after each row
//                pass.
//  Option      : BANK_READER_PERF_CNT_EN - when defined, stall_cycles counts
//                cycles with win_valid && !win_ready (saturating). When
//                undefined, stall_cycles is tied to zero.
//  Ports       : clk, rst           - clock, asynchronous active-high reset
//                cfg_width/height   - frame geometry, latched at frame_start
//                frame_start        - arms a new frame (ignored unless idle)
//                mb_full            - per-bank row-complete from the writer
//                mem_data           - bank read data (1-cycle read latency)
//                mb_rd_addr         - per-bank read address
//                mem_used           - per-bank release pulse
//                win_*              - window column stream (valid/ready)
//                frame_done, busy   - frame status
//                stall_cycles       - optional backpressure counter
//  Revision    : 1.0 - initial release
// ============================================================================
module bank_reader #(
   parameter int XB = 10,
   parameter int YB = 10,
   parameter int PB = 8,
   parameter int NM = 4,
   parameter int KW = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [XB-1:0] cfg_width,
   input  logic [YB-1:0] cfg_height,
   input  logic          frame_start,
   input  logic [NM-1:0] mb_full,
   input  logic [PB-1:0] mem_data   [NM],
   output logic [XB-1:0] mb_rd_addr [NM],
   output logic [NM-1:0] mem_used,
   output logic [PB-1:0] win_data   [KW],
   output logic          win_valid,
   input  logic          win_ready,
   output logic          win_first,
   output logic          win_last,
   output logic          frame_done,
   output logic          busy,
   output logic [15:0]   stall_cycles
);

   localparam int NB = (NM > 1) ? $clog2(NM) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WAIT    = 3'd1,
      S_STREAM  = 3'd2,
      S_DRAIN   = 3'd3,
      S_RELEASE = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t          state_q, state_d;
   logic [NM-1:0]   ready_q;
   logic [NB-1:0]   base_q,   base_d;
   logic [YB-1:0]   pass_q,   pass_d;
   logic [XB-1:0]   width_q,  width_d;
   logic [YB-1:0]   height_q, height_d;
   logic [XB-1:0]   col_q,    col_d;

   // One read can be in flight; its first/last tags ride along with it.
   logic            infl_q;
   logic            infl_first_q;
   logic            infl_last_q;

   // Two-entry output skid buffer
   logic [PB-1:0]   buf_data_q  [2][KW];
   logic [1:0]      buf_first_q;
   logic [1:0]      buf_last_q;
   logic            rd_ptr_q;
   logic            wr_ptr_q;
   logic [1:0]      occ_q;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   logic [NB-1:0]   w_bank [KW];
   logic [NM-1:0]   w_pass_mask;
   logic            w_all_ready;
   logic            w_pop;
   logic            w_push;
   logic [2:0]      w_credit;
   logic            w_issue;
   logic            w_col_last;
   logic            w_last_pass;
   logic [PB-1:0]   w_push_data [KW];

   // Banks of the current pass; NM is a power of two so the add wraps.
   always_comb begin
      w_pass_mask = '0;
      for (int k = 0; k < KW; k++) begin
         w_bank[k]              = base_q + NB'(k);
         w_pass_mask[w_bank[k]] = 1'b1;
      end
   end

   assign w_all_ready = ((ready_q & w_pass_mask) == w_pass_mask);
   assign w_pop       = win_valid && win_ready;
   assign w_push      = infl_q;

   // Occupancy the buffer will have after this cycle's pop, plus the read
   // already in flight. Counting the pop keeps full throughput at one
   // column per cycle while never overflowing the two entries.
   assign w_credit    = 3'(occ_q) + 3'(infl_q) - 3'(w_pop);
   assign w_issue     = (state_q == S_STREAM) && (w_credit < 3'd2);
   assign w_col_last  = (col_q == (width_q - XB'(1)));
   assign w_last_pass = ((pass_q + YB'(1)) == (height_q - YB'(KW - 1)));

   // Read data is reordered so index 0 is the oldest row (bank at base).
   always_comb begin
      for (int k = 0; k < KW; k++) begin
         w_push_data[k] = mem_data[w_bank[k]];
      end
   end

   // ------------------------------------------------------------------------
   // Read addresses: all pass banks share the column address while streaming
   // ------------------------------------------------------------------------
   always_comb begin
      for (int b = 0; b < NM; b++) begin
         mb_rd_addr[b] = '0;
         if ((state_q == S_STREAM) && w_pass_mask[b]) begin
            mb_rd_addr[b] = col_q;
         end
      end
   end

   // ------------------------------------------------------------------------
   // FSM next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      pass_d   = pass_q;
      width_d  = width_q;
      height_d = height_q;
      col_d    = col_q;
      case (state_q)
         S_IDLE: begin
            if (frame_start) begin
               state_d  = S_WAIT;
               base_d   = '0;
               pass_d   = '0;
               width_d  = cfg_width;
               height_d = cfg_height;
            end
         end
         S_WAIT: begin
            if (w_all_ready) begin
               state_d = S_STREAM;
               col_d   = '0;
            end
         end
         S_STREAM: begin
            if (w_issue) begin
               col_d = col_q + XB'(1);
               if (w_col_last) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if ((occ_q == 2'd0) && !infl_q) begin
               state_d = S_RELEASE;
            end
         end
         S_RELEASE: begin
            base_d  = base_q + NB'(1);
            pass_d  = pass_q + YB'(1);
            state_d = w_last_pass ? S_DONE : S_WAIT;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         pass_q   <= '0;
         width_q  <= '0;
         height_q <= '0;
         col_q    <= '0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         pass_q   <= pass_d;
         width_q  <= width_d;
         height_q <= height_d;
         col_q    <= col_d;
      end
   end

   // ------------------------------------------------------------------------
   // Bank status: a level on mb_full sets the flag and wins over a release
   // occurring in the same cycle.
   // ------------------------------------------------------------------------
   assign mem_used = (state_q == S_RELEASE) ? (NM'(1) << base_q) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q <= '0;
      end else begin
         ready_q <= (ready_q & ~mem_used) | mb_full;
      end
   end

   // ------------------------------------------------------------------------
   // Read pipeline and output skid buffer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         infl_q       <= 1'b0;
         infl_first_q <= 1'b0;
         infl_last_q  <= 1'b0;
      end else begin
         infl_q       <= w_issue;
         infl_first_q <= w_issue && (col_q == '0);
         infl_last_q  <= w_issue && w_col_last;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int e = 0; e < 2; e++) begin
            for (int k = 0; k < KW; k++) begin
               buf_data_q[e][k] <= '0;
            end
         end
         buf_first_q <= '0;
         buf_last_q  <= '0;
         rd_ptr_q    <= 1'b0;
         wr_ptr_q    <= 1'b0;
         occ_q       <= '0;
      end else begin
         if (w_push) begin
            for (int k = 0; k < KW; k++) begin
               buf_data_q[wr_ptr_q][k] <= w_push_data[k];
            end
            buf_first_q[wr_ptr_q] <= infl_first_q;
            buf_last_q[wr_ptr_q]  <= infl_last_q;
            wr_ptr_q              <= ~wr_ptr_q;
         end
         if (w_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         occ_q <= occ_q + 2'(w_push) - 2'(w_pop);
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   generate
      for (genvar k = 0; k < KW; k++) begin : g_win
         assign win_data[k] = buf_data_q[rd_ptr_q][k];
      end
   endgenerate

   assign win_valid  = (occ_q != 2'd0);
   assign win_first  = win_valid && buf_first_q[rd_ptr_q];
   assign win_last   = win_valid && buf_last_q[rd_ptr_q];
   assign frame_done = (state_q == S_DONE);
   assign busy       = (state_q != S_IDLE);

`ifdef BANK_READER_PERF_CNT_EN
   logic [15:0] stall_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q <= '0;
      end else if ((state_q == S_IDLE) && frame_start) begin
         stall_q <= '0;
      end else if (win_valid && !win_ready && (stall_q != 16'hFFFF)) begin
         stall_q <= stall_q + 16'd1;
      end
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bank_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bank_reader
//  Description : Scoreboard bench for bank_reader. Bank contents are modelled
//                as row_id*16 + column, so every expected window column is
//                known from the row numbers alone.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bank_reader;

   localparam int XB = 10;
   localparam int YB = 10;
   localparam int PB = 8;
   localparam int NM = 4;
   localparam int KW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [XB-1:0] cfg_width = '0;
   logic [YB-1:0] cfg_height = '0;
   logic          frame_start = 1'b0;
   logic [NM-1:0] mb_full = '0;
   logic [PB-1:0] mem_data [NM];
   logic [XB-1:0] mb_rd_addr [NM];
   logic [NM-1:0] mem_used;
   logic [PB-1:0] win_data [KW];
   logic          win_valid;
   logic          win_ready = 1'b1;
   logic          win_first;
   logic          win_last;
   logic          frame_done;
   logic          busy;
   logic [15:0]   stall_cycles;

   bank_reader #(.XB(XB), .YB(YB), .PB(PB), .NM(NM), .KW(KW)) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_width    (cfg_width),
      .cfg_height   (cfg_height),
      .frame_start  (frame_start),
      .mb_full      (mb_full),
      .mem_data     (mem_data),
      .mb_rd_addr   (mb_rd_addr),
      .mem_used     (mem_used),
      .win_data     (win_data),
      .win_valid    (win_valid),
      .win_ready    (win_ready),
      .win_first    (win_first),
      .win_last     (win_last),
      .frame_done   (frame_done),
      .busy         (busy),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   // Bank memory model: synchronous read, one cycle latency.
   logic [7:0] rowid [NM];
   initial for (int b = 0; b < NM; b++) rowid[b] = 8'd0;
   always @(posedge clk) begin
      for (int b = 0; b < NM; b++) begin
         mem_data[b] <= 8'(rowid[b] * 16 + 32'(mb_rd_addr[b][3:0]));
      end
   end

   typedef struct packed {
      logic [PB*KW-1:0] d;
      logic             f;
      logic             l;
   } exp_t;

   exp_t exp_q[$];
   int   used_q[$];
   int   errors = 0;
   int   checks = 0;
   int   acc_cnt = 0;
   int   done_cnt = 0;
   int   cyc = 0;
   int   first_acc_cyc = 0;
   int   last_acc_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   function automatic logic [PB*KW-1:0] pack_win();
      logic [PB*KW-1:0] p;
      for (int k = 0; k < KW; k++) p[k*PB +: PB] = win_data[k];
      return p;
   endfunction

   // ------------------------------------------------------------------------
   // Monitor: compares every accepted window and every release pulse
   // ------------------------------------------------------------------------
   exp_t             mon_e;
   logic             prev_stall = 1'b0;
   logic [PB*KW-1:0] prev_data;
   int               mon_b;

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("hold_valid", 64'(win_valid), 64'd1);
            chk("hold_data", 64'(pack_win()), 64'(prev_data));
         end
         if (win_valid && win_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_window", 64'd1, 64'd0);
            end else begin
               mon_e = exp_q.pop_front();
               chk("win_data", 64'(pack_win()), 64'(mon_e.d));
               chk("win_first", 64'(win_first), 64'(mon_e.f));
               chk("win_last", 64'(win_last), 64'(mon_e.l));
            end
            acc_cnt++;
            if (acc_cnt == 1) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
         end
         if (mem_used != '0) begin
            if (used_q.size() == 0) begin
               chk("unexpected_mem_used", 64'(mem_used), 64'd0);
            end else begin
               mon_b = used_q.pop_front();
               chk("mem_used", 64'(mem_used), 64'(1 << mon_b));
            end
         end
         if (frame_done) done_cnt++;
         prev_stall = win_valid && !win_ready;
         prev_data  = pack_win();
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------------
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fill(input int b, input int row);
      rowid[b]   = 8'(row);
      mb_full[b] = 1'b1;
      tick(1);
      mb_full[b] = 1'b0;
   endtask

   // Pushes the expected windows and releases of a frame starting at base 0,
   // where row r lives in bank r mod NM.
   task automatic start_frame(input int w, input int h);
      exp_t e;
      cfg_width  = XB'(w);
      cfg_height = YB'(h);
      for (int p = 0; p <= h - KW; p++) begin
         for (int c = 0; c < w; c++) begin
            for (int k = 0; k < KW; k++) e.d[k*PB +: PB] = 8'((p + k) * 16 + c);
            e.f = (c == 0);
            e.l = (c == w - 1);
            exp_q.push_back(e);
         end
         used_q.push_back(p % NM);
      end
      frame_start = 1'b1;
      tick(1);
      frame_start = 1'b0;
   endtask

   task automatic wait_done(input int target, input string name);
      int n = 0;
      while (done_cnt < target && n < 2000) begin
         tick(1);
         n++;
      end
      chk(name, 64'(done_cnt >= target), 64'd1);
   endtask

   task automatic end_test(input string name);
      chk({name, "_windows_left"}, 64'(exp_q.size()), 64'd0);
      chk({name, "_releases_left"}, 64'(used_q.size()), 64'd0);
      chk({name, "_busy_end"}, 64'(busy), 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mb_full = '0;
      frame_start = 1'b0;
      win_ready = 1'b1;
      tick(2);
      exp_q.delete();
      used_q.delete();
      rst = 1'b0;
      acc_cnt = 0;
      done_cnt = 0;
      tick(1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   // Directed tests
   // ------------------------------------------------------------------------
   initial begin
      int n;
      int lat;
      int seen;
      int stall_exp;

      // Reset state
      tick(2);
      chk("rst_win_valid", 64'(win_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mem_used", 64'(mem_used), 64'd0);
      chk("rst_frame_done", 64'(frame_done), 64'd0);
      chk("rst_stall", 64'(stall_cycles), 64'd0);
      chk("rst_addr0", 64'(mb_rd_addr[0]), 64'd0);
      do_reset();

      // Basic frame: 4 columns, single pass
      fill(0, 0); fill(1, 1); fill(2, 2);
      start_frame(4, 3);
      chk("basic_busy", 64'(busy), 64'd1);
      wait_done(1, "basic_done");
      chk("basic_count", 64'(acc_cnt), 64'd4);
      chk("basic_consecutive", 64'(last_acc_cyc - first_acc_cyc), 64'd3);
      end_test("basic");

      // Multi-pass wrap: 4 passes, banks 0 and 1 refilled after release
      do_reset();
      fill(0, 0); fill(1, 1); fill(2, 2); fill(3, 3);
      start_frame(3, 6);
      fork
         begin
            int nxt = 4;
            int m = 0;
            while (nxt < 6 && m < 3000) begin
               tick(1);
               m++;
               for (int b = 0; b < NM; b++) begin
                  if (mem_used[b] && nxt < 6) begin
                     tick(2);
                     fill(b, nxt);
                     nxt++;
                  end
               end
            end
         end
         wait_done(1, "wrap_done");
      join
      chk("wrap_count", 64'(acc_cnt), 64'd12);
      end_test("wrap");

      // Backpressure: win_ready low for 5 cycles mid-row
      do_reset();
      fill(0, 0); fill(1, 1); fill(2, 2);
      start_frame(8, 3);
      n = 0;
      while (!(win_valid && win_first) && n < 100) begin tick(1); n++; end
      chk("bp_first_seen", 64'(win_valid && win_first), 64'd1);
      tick(2);
      win_ready = 1'b0;
      tick(5);
      win_ready = 1'b1;
      wait_done(1, "bp_done");
      chk("bp_count", 64'(acc_cnt), 64'd8);
`ifdef BANK_READER_PERF_CNT_EN
      stall_exp = 5;
`else
      stall_exp = 0;
`endif
      chk("bp_stall_cycles", 64'(stall_cycles), 64'(stall_exp));
      end_test("bp");

      // Starvation: only banks 0 and 1 full
      do_reset();
      fill(0, 0); fill(1, 1);
      start_frame(2, 3);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (win_valid) seen = 1;
      end
      chk("starve_no_valid", 64'(seen), 64'd0);
      chk("starve_busy", 64'(busy), 64'd1);
      rowid[2] = 8'd2;
      mb_full[2] = 1'b1;
      tick(1);
      mb_full[2] = 1'b0;
      lat = 1;
      while (!win_valid && lat < 20) begin tick(1); lat++; end
      chk("starve_latency", 64'(lat), 64'd4);
      wait_done(1, "starve_done");
      end_test("starve");

      // Simultaneous set/clear on bank 0
      do_reset();
      fill(0, 0); fill(1, 1); fill(2, 2);
      start_frame(2, 3);
      n = 0;
      while (!mem_used[0] && n < 200) begin tick(1); n++; end
      chk("sc_release_seen", 64'(mem_used[0]), 64'd1);
      mb_full[0] = 1'b1;
      tick(1);
      mb_full[0] = 1'b0;
      wait_done(1, "sc_done1");
      start_frame(2, 3);
      wait_done(2, "sc_done2_flag_kept");
      end_test("sc");

      // Reset mid-row after 2 columns
      do_reset();
      fill(0, 0); fill(1, 1); fill(2, 2);
      start_frame(8, 3);
      n = 0;
      while (acc_cnt < 2 && n < 100) begin tick(1); n++; end
      chk("mr_two_cols", 64'(acc_cnt >= 2), 64'd1);
      rst = 1'b1;
      #1;
      chk("mr_win_valid", 64'(win_valid), 64'd0);
      chk("mr_busy", 64'(busy), 64'd0);
      chk("mr_mem_used", 64'(mem_used), 64'd0);
      chk("mr_first_last", 64'({win_first, win_last}), 64'd0);
      chk("mr_win_data", 64'(pack_win()), 64'd0);
      chk("mr_addr", 64'(mb_rd_addr[0] | mb_rd_addr[1] | mb_rd_addr[2]), 64'd0);
      do_reset();
      fill(0, 0); fill(1, 1); fill(2, 2);
      start_frame(2, 3);
      wait_done(1, "mr_restart_done");
      chk("mr_restart_count", 64'(acc_cnt), 64'd2);
      end_test("mr");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
